// File: rtl/dma_channel_arbiter.sv
// Four-channel DREQ arbiter with HRQ/HLDA bus-hold sequencing and fixed/rotating priority.
// Optional HLDA wait timeout is built when DMA_ARB_HOLD_TIMEOUT_EN is defined.
module dma_channel_arbiter #(
  parameter logic [7:0] HOLD_TIMEOUT = 8'd255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DREQ,
  input  logic       HLDA,
  input  logic [3:0] maskReg,
  input  logic       priorityType,
  input  logic       transferDone,
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic       grantValid,
  output logic [1:0] grantChannel,
  output logic [7:0] priorityOrder,
  output logic       holdTimeout
);

  localparam logic [7:0] FIXED_ORDER = 8'b11_10_01_00;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GRANT,
    RELEASE
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [3:0] elig;
  logic [1:0] win;
  logic       win_found;
  logic [1:0] grant_n;
  logic       rot_mode;
  logic       rot_upd;
  logic [7:0] rot_order;
  logic       to_hit;
  logic       to_fire;

  assign elig = DREQ & ~maskReg;

  // Completed channel drops to the lowest slot; the next one up leads.
  assign rot_order = {grantChannel,
                      grantChannel + 2'd3,
                      grantChannel + 2'd2,
                      grantChannel + 2'd1};

  always_comb begin
    win       = priorityOrder[1:0];
    win_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!win_found && elig[priorityOrder[2*i +: 2]]) begin
        win       = priorityOrder[2*i +: 2];
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grantChannel;
    rot_upd = 1'b0;
    to_fire = 1'b0;
    unique case (state)
      IDLE: begin
        if (|elig)
          state_n = REQ;
      end
      REQ: begin
        if (!(|elig)) begin
          state_n = IDLE;
        end else if (HLDA) begin
          state_n = GRANT;
          grant_n = win;
        end else if (to_hit) begin
          state_n = RELEASE;
          to_fire = 1'b1;
        end
      end
      GRANT: begin
        if (transferDone) begin
          state_n = RELEASE;
          rot_upd = rot_mode;
        end else if (!HLDA) begin
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      HRQ           <= 1'b0;
      DACK          <= 4'b0000;
      grantValid    <= 1'b0;
      grantChannel  <= 2'b00;
      priorityOrder <= FIXED_ORDER;
      rot_mode      <= 1'b0;
    end else begin
      state        <= state_n;
      HRQ          <= (state_n == REQ) || (state_n == GRANT);
      grantValid   <= (state_n == GRANT);
      DACK         <= (state_n == GRANT) ? (4'b0001 << grant_n) : 4'b0000;
      grantChannel <= grant_n;
      if (state == IDLE) begin
        rot_mode <= priorityType;
        if (!priorityType)
          priorityOrder <= FIXED_ORDER;
      end
      if (rot_upd)
        priorityOrder <= rot_order;
    end
  end

`ifdef DMA_ARB_HOLD_TIMEOUT_EN
  logic [7:0] hold_cnt;

  assign to_hit = ({1'b0, hold_cnt} + 9'd1) >= {1'b0, HOLD_TIMEOUT};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hold_cnt    <= 8'd0;
      holdTimeout <= 1'b0;
    end else begin
      if (state != REQ)
        hold_cnt <= 8'd0;
      else if (hold_cnt != 8'hff)
        hold_cnt <= hold_cnt + 8'd1;
      if (to_fire)
        holdTimeout <= 1'b1;
    end
  end
`else
  logic timeout_unused;

  assign timeout_unused = ^{HOLD_TIMEOUT, to_fire};
  assign to_hit         = 1'b0;
  assign holdTimeout    = 1'b0;
`endif

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter.
// Inputs change and outputs are checked 1ns after each rising edge.
module tb_dma_channel_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic       HLDA;
  logic [3:0] maskReg;
  logic       priorityType;
  logic       transferDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic       grantValid;
  logic [1:0] grantChannel;
  logic [7:0] priorityOrder;
  logic       holdTimeout;

  int total = 0;
  int bad   = 0;

  logic [7:0] rot_exp [4];

  always #5 CLK = ~CLK;

  dma_channel_arbiter #(.HOLD_TIMEOUT(8'd4)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .DREQ(DREQ),
    .HLDA(HLDA),
    .maskReg(maskReg),
    .priorityType(priorityType),
    .transferDone(transferDone),
    .HRQ(HRQ),
    .DACK(DACK),
    .grantValid(grantValid),
    .grantChannel(grantChannel),
    .priorityOrder(priorityOrder),
    .holdTimeout(holdTimeout)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    rot_exp[0] = 8'b00_11_10_01;
    rot_exp[1] = 8'b01_00_11_10;
    rot_exp[2] = 8'b10_01_00_11;
    rot_exp[3] = 8'b11_10_01_00;

    RESET = 1'b1;
    DREQ = 4'b0000;
    HLDA = 1'b0;
    maskReg = 4'b0000;
    priorityType = 1'b0;
    transferDone = 1'b0;
    step();
    step();
    check("rst_hrq", HRQ, 1'b0);
    check("rst_dack", DACK, 4'b0000);
    check("rst_gv", grantValid, 1'b0);
    check("rst_gch", grantChannel, 2'b00);
    check("rst_order", priorityOrder, 8'b11_10_01_00);
    check("rst_to", holdTimeout, 1'b0);
    RESET = 1'b0;

    // fixed priority, several requesters
    DREQ = 4'b1110;
    step();
    check("fx_hrq", HRQ, 1'b1);
    check("fx_dack0", DACK, 4'b0000);
    HLDA = 1'b1;
    step();
    check("fx_dack", DACK, 4'b0010);
    check("fx_gv", grantValid, 1'b1);
    check("fx_gch", grantChannel, 2'd1);
    DREQ = 4'b0001;
    maskReg = 4'b0010;
    step();
    check("fx_hold", DACK, 4'b0010);
    transferDone = 1'b1;
    step();
    transferDone = 1'b0;
    maskReg = 4'b0000;
    check("fx_rel_dack", DACK, 4'b0000);
    check("fx_rel_hrq", HRQ, 1'b0);
    check("fx_rel_gv", grantValid, 1'b0);
    check("fx_order", priorityOrder, 8'b11_10_01_00);
    step();
    check("fx_gap_hrq", HRQ, 1'b0);
    step();
    check("fx_next_hrq", HRQ, 1'b1);
    step();
    check("fx_next_dack", DACK, 4'b0001);
    DREQ = 4'b0000;
    transferDone = 1'b1;
    step();
    transferDone = 1'b0;
    step();

    // rotating priority, all channels requesting
    priorityType = 1'b1;
    DREQ = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rot_hrq", HRQ, 1'b1);
      step();
      check("rot_dack", DACK, 4'b0001 << k);
      transferDone = 1'b1;
      step();
      transferDone = 1'b0;
      check("rot_rel", DACK, 4'b0000);
      check("rot_order", priorityOrder, rot_exp[k]);
      step();
    end
    DREQ = 4'b0000;
    HLDA = 1'b0;
    step();

    // HLDA abort on channel 1
    DREQ = 4'b0010;
    HLDA = 1'b1;
    step();
    step();
    check("ab_dack", DACK, 4'b0010);
    HLDA = 1'b0;
    step();
    check("ab_dack_off", DACK, 4'b0000);
    check("ab_hrq_off", HRQ, 1'b0);
    check("ab_order", priorityOrder, 8'b11_10_01_00);
    DREQ = 4'b0000;
    step();

    // masking, then withdrawal before HLDA
    maskReg = 4'b0001;
    DREQ = 4'b0001;
    step();
    step();
    step();
    check("mk_hrq", HRQ, 1'b0);
    maskReg = 4'b0000;
    DREQ = 4'b0100;
    step();
    check("wd_hrq_on", HRQ, 1'b1);
    DREQ = 4'b0000;
    step();
    check("wd_hrq_off", HRQ, 1'b0);
    check("wd_dack", DACK, 4'b0000);
    HLDA = 1'b1;
    step();
    check("wd_dack2", DACK, 4'b0000);
    check("wd_hrq2", HRQ, 1'b0);

    // transferDone with HLDA falling together still rotates
    DREQ = 4'b0100;
    step();
    step();
    check("sim_dack", DACK, 4'b0100);
    transferDone = 1'b1;
    HLDA = 1'b0;
    step();
    transferDone = 1'b0;
    check("sim_order", priorityOrder, 8'b10_01_00_11);
    check("sim_dack_off", DACK, 4'b0000);
    step();

    // reset mid-grant on channel 2
    HLDA = 1'b1;
    step();
    step();
    check("rg_dack", DACK, 4'b0100);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("rg_dack_off", DACK, 4'b0000);
    check("rg_hrq", HRQ, 1'b0);
    check("rg_order", priorityOrder, 8'b11_10_01_00);
    DREQ = 4'b0000;
    HLDA = 1'b0;
    step();

    // HLDA never comes
    DREQ = 4'b0001;
    step();
    check("to_hrq_on", HRQ, 1'b1);
`ifdef DMA_ARB_HOLD_TIMEOUT_EN
    step();
    step();
    step();
    check("to_hrq_wait", HRQ, 1'b1);
    check("to_flag_pre", holdTimeout, 1'b0);
    step();
    check("to_hrq_drop", HRQ, 1'b0);
    check("to_flag", holdTimeout, 1'b1);
    DREQ = 4'b0000;
    step();
    step();
    step();
    check("to_sticky", holdTimeout, 1'b1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("to_clear", holdTimeout, 1'b0);
`else
    for (int i = 0; i < 10; i++)
      step();
    check("nto_hrq", HRQ, 1'b1);
    check("nto_flag", holdTimeout, 1'b0);
    check("nto_dack", DACK, 4'b0000);
    DREQ = 4'b0000;
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
